idwt_2: RTL and testbench



---
 rtl/idwt_2.sv | 175 +++++++++++++++++
 tb/tb_idwt_2.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/idwt_2.sv
// Level-2 inverse DWT: 6+6 parallel coefficients in, 12 serial samples out via 4-tap polyphase synthesis.
// Latency 2 cycles accept->first sample; in_ready only in IDLE or on the last sample slot, so blocks stream gaplessly.
module idwt_2 #(
  parameter int y_out = 25,
  parameter int c_in  = 9,
  parameter int LR0   = 124,
  parameter int LR1   = 214,
  parameter int LR2   = 57,
  parameter int LR3   = -33,
  parameter int HR0   = -33,
  parameter int HR1   = -57,
  parameter int HR2   = 214,
  parameter int HR3   = -124,
  parameter int SHIFT = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    Lo_D2_valid,
  input  logic signed [y_out-1:0] Lo_D2_c_y_6k,
  input  logic signed [y_out-1:0] Lo_D2_c_y_6k_1,
  input  logic signed [y_out-1:0] Lo_D2_c_y_6k_2,
  input  logic signed [y_out-1:0] Lo_D2_c_y_6k_3,
  input  logic signed [y_out-1:0] Lo_D2_c_y_6k_4,
  input  logic signed [y_out-1:0] Lo_D2_c_y_6k_5,
  input  logic                    Hi_D2_valid,
  input  logic signed [y_out-1:0] Hi_D2_c_y_6k,
  input  logic signed [y_out-1:0] Hi_D2_c_y_6k_1,
  input  logic signed [y_out-1:0] Hi_D2_c_y_6k_2,
  input  logic signed [y_out-1:0] Hi_D2_c_y_6k_3,
  input  logic signed [y_out-1:0] Hi_D2_c_y_6k_4,
  input  logic signed [y_out-1:0] Hi_D2_c_y_6k_5,
  output logic                    in_ready,
  output logic                    Lo_R_valid,
  output logic signed [y_out-1:0] Lo_R_y,
  output logic                    sync_err,
  output logic                    ovf_err
);

  localparam int PW = y_out + c_in;
  localparam int SW = PW + 2;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  typedef logic signed [y_out-1:0] smp_t;
  typedef logic signed [c_in-1:0]  coef_t;

  localparam coef_t K_LR0 = coef_t'(LR0);
  localparam coef_t K_LR1 = coef_t'(LR1);
  localparam coef_t K_LR2 = coef_t'(LR2);
  localparam coef_t K_LR3 = coef_t'(LR3);
  localparam coef_t K_HR0 = coef_t'(HR0);
  localparam coef_t K_HR1 = coef_t'(HR1);
  localparam coef_t K_HR2 = coef_t'(HR2);
  localparam coef_t K_HR3 = coef_t'(HR3);

  smp_t a_in [6];
  smp_t d_in [6];
  smp_t a_q [6];
  smp_t d_q [6];
  smp_t a_prev_q, d_prev_q;

  logic [0:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       rdy_en_q;
  logic       v1_q, vld_q;
  logic       sync_q, ovf_q;
  smp_t       y_q, y_d;

  logic signed [PW-1:0] p_q [4];
  logic signed [PW-1:0] p_d [4];
  logic signed [SW-1:0] sum;

  logic       both, accept, last;
  logic [2:0] n;
  smp_t       a_n, a_m1, d_n, d_m1;
  coef_t      k0, k1, k2, k3;

  always_comb begin
    a_in[0] = Lo_D2_c_y_6k;   d_in[0] = Hi_D2_c_y_6k;
    a_in[1] = Lo_D2_c_y_6k_1; d_in[1] = Hi_D2_c_y_6k_1;
    a_in[2] = Lo_D2_c_y_6k_2; d_in[2] = Hi_D2_c_y_6k_2;
    a_in[3] = Lo_D2_c_y_6k_3; d_in[3] = Hi_D2_c_y_6k_3;
    a_in[4] = Lo_D2_c_y_6k_4; d_in[4] = Hi_D2_c_y_6k_4;
    a_in[5] = Lo_D2_c_y_6k_5; d_in[5] = Hi_D2_c_y_6k_5;
  end

  always_comb begin
    both     = Lo_D2_valid & Hi_D2_valid;
    last     = (state_q == RUN) && (cnt_q == 4'd11);
    in_ready = rdy_en_q & ((state_q == IDLE) | last);
    accept   = both & in_ready;
    state_d  = state_q;
    cnt_d    = cnt_q;
    if (state_q == IDLE) begin
      if (accept) begin
        state_d = RUN;
        cnt_d   = 4'd0;
      end
    end else if (!last) begin
      cnt_d = cnt_q + 4'd1;
    end else if (accept) begin
      cnt_d = 4'd0;
    end else begin
      state_d = IDLE;
    end
  end

  // Stage 1: even/odd output phase selects the polyphase tap set for pair n.
  always_comb begin
    n    = cnt_q[3:1];
    a_n  = a_q[n];
    d_n  = d_q[n];
    a_m1 = (n == 3'd0) ? a_prev_q : a_q[n - 3'd1];
    d_m1 = (n == 3'd0) ? d_prev_q : d_q[n - 3'd1];
    if (cnt_q[0]) begin
      k0 = K_LR1; k1 = K_LR3; k2 = K_HR1; k3 = K_HR3;
    end else begin
      k0 = K_LR0; k1 = K_LR2; k2 = K_HR0; k3 = K_HR2;
    end
    p_d[0] = PW'(a_n)  * PW'(k0);
    p_d[1] = PW'(a_m1) * PW'(k1);
    p_d[2] = PW'(d_n)  * PW'(k2);
    p_d[3] = PW'(d_m1) * PW'(k3);
  end

  // Stage 2: floor shift, then wrap to the output width.
  always_comb begin
    sum = SW'(p_q[0]) + SW'(p_q[1]) + SW'(p_q[2]) + SW'(p_q[3]);
    y_d = smp_t'(sum >>> SHIFT);
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 6; i++) begin
      if (accept) begin
        a_q[i] <= a_in[i];
        d_q[i] <= d_in[i];
      end
    end
    for (int i = 0; i < 4; i++) p_q[i] <= p_d[i];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      rdy_en_q <= 1'b0;
      a_prev_q <= '0;
      d_prev_q <= '0;
      v1_q     <= 1'b0;
      vld_q    <= 1'b0;
      y_q      <= '0;
      sync_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdy_en_q <= 1'b1;
      if (last) begin
        a_prev_q <= a_q[5];
        d_prev_q <= d_q[5];
      end
      v1_q  <= (state_q == RUN);
      vld_q <= v1_q;
      if (v1_q) y_q <= y_d;
      sync_q <= sync_q | (Lo_D2_valid ^ Hi_D2_valid);
      ovf_q  <= ovf_q | (both & ~in_ready);
    end
  end

  assign Lo_R_valid = vld_q;
  assign Lo_R_y     = y_q;
  assign sync_err   = sync_q;
  assign ovf_err    = ovf_q;

endmodule

// File: tb/tb_idwt_2.sv
// Bench for idwt_2: directed and random blocks against an arithmetic reference of the synthesis filter.
module tb_idwt_2;

  logic clk, rstn, lo_v, hi_v;
  logic signed [24:0] a_in [6];
  logic signed [24:0] d_in [6];
  logic in_ready, Lo_R_valid, sync_err, ovf_err;
  logic signed [24:0] Lo_R_y;

  int checks = 0;
  int errors = 0;

  longint blk_a [6];
  longint blk_d [6];
  longint m_aprev, m_dprev, last_y;
  longint exp_q [$];

  idwt_2 dut (
    .clk(clk), .rstn(rstn),
    .Lo_D2_valid(lo_v),
    .Lo_D2_c_y_6k(a_in[0]), .Lo_D2_c_y_6k_1(a_in[1]), .Lo_D2_c_y_6k_2(a_in[2]),
    .Lo_D2_c_y_6k_3(a_in[3]), .Lo_D2_c_y_6k_4(a_in[4]), .Lo_D2_c_y_6k_5(a_in[5]),
    .Hi_D2_valid(hi_v),
    .Hi_D2_c_y_6k(d_in[0]), .Hi_D2_c_y_6k_1(d_in[1]), .Hi_D2_c_y_6k_2(d_in[2]),
    .Hi_D2_c_y_6k_3(d_in[3]), .Hi_D2_c_y_6k_4(d_in[4]), .Hi_D2_c_y_6k_5(d_in[5]),
    .in_ready(in_ready), .Lo_R_valid(Lo_R_valid), .Lo_R_y(Lo_R_y),
    .sync_err(sync_err), .ovf_err(ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Floor division by 2^8, then wrap to a signed 25-bit value.
  function automatic longint floor_wrap(input longint s);
    longint q;
    q = (s >= 0) ? s / 256 : -((-s + 255) / 256);
    q = q & 64'h1FF_FFFF;
    if (q >= 64'sd16777216) q = q - 64'sd33554432;
    return q;
  endfunction

  task automatic model_block();
    longint am1, dm1;
    for (int n = 0; n < 6; n++) begin
      am1 = (n == 0) ? m_aprev : blk_a[n-1];
      dm1 = (n == 0) ? m_dprev : blk_d[n-1];
      exp_q.push_back(floor_wrap(124*blk_a[n] + 57*am1 - 33*blk_d[n] + 214*dm1));
      exp_q.push_back(floor_wrap(214*blk_a[n] - 33*am1 - 57*blk_d[n] - 124*dm1));
    end
    m_aprev = blk_a[5];
    m_dprev = blk_d[5];
  endtask

  task automatic drive_block(input bit rnd, input longint av, input longint dv);
    logic signed [24:0] r;
    for (int i = 0; i < 6; i++) begin
      if (rnd) begin
        r = 25'($urandom); blk_a[i] = r;
        r = 25'($urandom); blk_d[i] = r;
      end else begin
        blk_a[i] = av;
        blk_d[i] = dv;
      end
      a_in[i] = 25'(blk_a[i]);
      d_in[i] = 25'(blk_d[i]);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0; lo_v = 1'b0; hi_v = 1'b0;
    tick();
    tick();
    m_aprev = 0; m_dprev = 0; last_y = 0;
    exp_q.delete();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0; lo_v = 1'b0; hi_v = 1'b0;
    tick();
    tick();
    checks += 5;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
    if (Lo_R_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", Lo_R_valid); end
    if (Lo_R_y !== 25'sd0) begin errors++; $display("FAIL rst_y got %0d exp 0", Lo_R_y); end
    if (sync_err !== 1'b0) begin errors++; $display("FAIL rst_sync got %b exp 0", sync_err); end
    if (ovf_err !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b exp 0", ovf_err); end
    m_aprev = 0; m_dprev = 0; last_y = 0;
    exp_q.delete();
    rstn = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_single(input string name, input longint av, input longint dv);
    longint cur;
    bit ev;
    drive_block(1'b0, av, dv);
    lo_v = 1'b1; hi_v = 1'b1;
    tick();
    lo_v = 1'b0; hi_v = 1'b0;
    model_block();
    for (int k = 1; k <= 14; k++) begin
      tick();
      ev = (k >= 2) && (k <= 13);
      if (ev) last_y = exp_q.pop_front();
      cur = last_y;
      checks += 3;
      if (Lo_R_valid !== ev) begin errors++; $display("FAIL %s valid k=%0d got %b exp %b", name, k, Lo_R_valid, ev); end
      if (Lo_R_y !== 25'(cur)) begin errors++; $display("FAIL %s y k=%0d got %0d exp %0d", name, k, Lo_R_y, cur); end
      if (in_ready !== (k >= 11)) begin errors++; $display("FAIL %s in_ready k=%0d got %b exp %b", name, k, in_ready, k >= 11); end
    end
    checks += 2;
    if (sync_err !== 1'b0) begin errors++; $display("FAIL %s sync got %b exp 0", name, sync_err); end
    if (ovf_err !== 1'b0) begin errors++; $display("FAIL %s ovf got %b exp 0", name, ovf_err); end
  endtask

  task automatic test_back_to_back(input int nb, input bit rnd);
    bit ev, er;
    for (int k = 0; k <= 12*nb + 2; k++) begin
      if ((k % 12 == 0) && (k / 12 < nb)) begin
        drive_block(rnd, 256, 0);
        lo_v = 1'b1; hi_v = 1'b1;
        model_block();
      end else begin
        lo_v = 1'b0; hi_v = 1'b0;
      end
      tick();
      ev = (k >= 2) && (k <= 12*nb + 1);
      er = (k % 12 == 11) || (k >= 12*nb);
      if (ev) last_y = exp_q.pop_front();
      checks += 3;
      if (Lo_R_valid !== ev) begin errors++; $display("FAIL b2b valid k=%0d got %b exp %b", k, Lo_R_valid, ev); end
      if (Lo_R_y !== 25'(last_y)) begin errors++; $display("FAIL b2b y k=%0d got %0d exp %0d", k, Lo_R_y, last_y); end
      if (in_ready !== er) begin errors++; $display("FAIL b2b in_ready k=%0d got %b exp %b", k, in_ready, er); end
    end
    lo_v = 1'b0; hi_v = 1'b0;
    checks += 2;
    if (ovf_err !== 1'b0) begin errors++; $display("FAIL b2b ovf got %b exp 0", ovf_err); end
    if (sync_err !== 1'b0) begin errors++; $display("FAIL b2b sync got %b exp 0", sync_err); end
  endtask

  task automatic test_overflow();
    bit ev, er, eo;
    drive_block(1'b0, 256, 0);
    lo_v = 1'b1; hi_v = 1'b1;
    model_block();
    tick();
    for (int k = 1; k <= 26; k++) begin
      if (k == 4) begin
        drive_block(1'b1, 0, 0);
        lo_v = 1'b1; hi_v = 1'b1;
      end else if (k == 12) begin
        drive_block(1'b1, 0, 0);
        lo_v = 1'b1; hi_v = 1'b1;
        model_block();
      end else begin
        lo_v = 1'b0; hi_v = 1'b0;
      end
      tick();
      ev = (k >= 2) && (k <= 25);
      er = (k % 12 == 11) || (k >= 24);
      eo = (k >= 4);
      if (ev) last_y = exp_q.pop_front();
      checks += 4;
      if (Lo_R_valid !== ev) begin errors++; $display("FAIL ovf_valid k=%0d got %b exp %b", k, Lo_R_valid, ev); end
      if (Lo_R_y !== 25'(last_y)) begin errors++; $display("FAIL ovf_y k=%0d got %0d exp %0d", k, Lo_R_y, last_y); end
      if (in_ready !== er) begin errors++; $display("FAIL ovf_in_ready k=%0d got %b exp %b", k, in_ready, er); end
      if (ovf_err !== eo) begin errors++; $display("FAIL ovf_flag k=%0d got %b exp %b", k, ovf_err, eo); end
    end
    lo_v = 1'b0; hi_v = 1'b0;
  endtask

  task automatic test_sync();
    lo_v = 1'b1; hi_v = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      lo_v = 1'b0;
      checks += 4;
      if (sync_err !== 1'b1) begin errors++; $display("FAIL sync_flag k=%0d got %b exp 1", k, sync_err); end
      if (Lo_R_valid !== 1'b0) begin errors++; $display("FAIL sync_valid k=%0d got %b exp 0", k, Lo_R_valid); end
      if (in_ready !== 1'b1) begin errors++; $display("FAIL sync_in_ready k=%0d got %b exp 1", k, in_ready); end
      if (ovf_err !== 1'b0) begin errors++; $display("FAIL sync_ovf k=%0d got %b exp 0", k, ovf_err); end
    end
  endtask

  task automatic test_reset_mid();
    drive_block(1'b0, 256, 0);
    lo_v = 1'b1; hi_v = 1'b1;
    model_block();
    tick();
    for (int k = 1; k <= 7; k++) begin
      lo_v = (k == 2);
      hi_v = 1'b0;
      tick();
      if (k >= 2) last_y = exp_q.pop_front();
      checks++;
      if (Lo_R_y !== 25'(last_y)) begin errors++; $display("FAIL mid_y k=%0d got %0d exp %0d", k, Lo_R_y, last_y); end
    end
    lo_v = 1'b0;
    rstn = 1'b0;
    tick();
    checks += 5;
    if (Lo_R_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", Lo_R_valid); end
    if (Lo_R_y !== 25'sd0) begin errors++; $display("FAIL mid_rst_y got %0d exp 0", Lo_R_y); end
    if (sync_err !== 1'b0) begin errors++; $display("FAIL mid_rst_sync got %b exp 0", sync_err); end
    if (ovf_err !== 1'b0) begin errors++; $display("FAIL mid_rst_ovf got %b exp 0", ovf_err); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_in_ready got %b exp 0", in_ready); end
    m_aprev = 0; m_dprev = 0; last_y = 0;
    exp_q.delete();
    rstn = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_release_in_ready got %b exp 1", in_ready); end
    test_single("after_mid_rst", 256, 0);
  endtask

  initial begin
    rstn = 1'b0; lo_v = 1'b0; hi_v = 1'b0;
    for (int i = 0; i < 6; i++) begin a_in[i] = '0; d_in[i] = '0; end
    m_aprev = 0; m_dprev = 0; last_y = 0;
    test_reset();
    test_single("approx_only", 256, 0);
    do_reset();
    test_single("detail_only", 0, 256);
    do_reset();
    test_back_to_back(3, 1'b0);
    test_back_to_back(4, 1'b1);
    do_reset();
    test_overflow();
    do_reset();
    test_sync();
    do_reset();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
